// File: rtl/dct_matmul_engine_if.sv
// rtl/dct_matmul_engine_if.sv - control handshake and RAM/ROM ports of the IDCT matmul engine
interface dct_matmul_engine_if #(
  parameter int DATA_W = 32,
  parameter int COEF_W = 16,
  parameter int LANES  = 4
);
  localparam int CW = 4 + $clog2(8 / LANES);

  logic                      start;
  logic [1:0]                mode;
  logic                      busy;
  logic                      done;
  logic [5:0]                a_rd_addr;
  logic [DATA_W-1:0]         a_rd_data;
  logic [5:0]                t_rd_addr;
  logic [DATA_W-1:0]         t_rd_data;
  logic [5:0]                t_wr_addr;
  logic [DATA_W-1:0]         t_wdata;
  logic                      t_we;
  logic [CW-1:0]             c_rd_addr;
  logic [LANES*COEF_W-1:0]   c_rd_data;
  logic [5:0]                s_wr_addr;
  logic [DATA_W-1:0]         s_wdata;
  logic                      s_we;

  modport master (
    input  start, mode, a_rd_data, t_rd_data, c_rd_data,
    output busy, done, a_rd_addr, t_rd_addr, t_wr_addr, t_wdata, t_we,
           c_rd_addr, s_wr_addr, s_wdata, s_we
  );

  modport slave (
    output start, mode, a_rd_data, t_rd_data, c_rd_data,
    input  busy, done, a_rd_addr, t_rd_addr, t_wr_addr, t_wdata, t_we,
           c_rd_addr, s_wr_addr, s_wdata, s_we
  );
endinterface

// File: rtl/dct_matmul_engine.sv
// rtl/dct_matmul_engine.sv - 8x8 IDCT matrix-multiply engine, LANES signed MACs
// Pass 1: T = (A*C) >>> SHIFT_T; pass 2: S = clip((T*C^T) >>> SHIFT_S).
module dct_matmul_engine #(
  parameter int DATA_W  = 32,
  parameter int COEF_W  = 16,
  parameter int LANES   = 4,
  parameter int SHIFT_T = 8,
  parameter int SHIFT_S = 16,
  parameter int CLIP    = 1
) (
  input logic                CLOCK_50_I,
  input logic                Resetn,
  dct_matmul_engine_if.master bus
);
  localparam int G     = 8 / LANES;
  localparam int GW    = $clog2(G);
  localparam int LW    = $clog2(LANES);
  localparam int P     = 512 / LANES;
  localparam int PW    = $clog2(P);
  localparam int GRW   = PW - 3;
  localparam int DLW   = (LANES > 1) ? LW : 1;
  localparam int PRW   = DATA_W + COEF_W;
  localparam int ACC_W = PRW + 3;
  localparam logic signed [ACC_W-1:0] MAXV = 255;

  typedef enum logic [2:0] {IDLE, RUN1, DRAIN1, RUN2, DRAIN2, DONE} state_t;

  state_t state, state_n;
  logic [PW-1:0] cnt;
  logic [1:0]    mode_r;
  logic          run, pass2, run_last, drain_last;

  assign run        = (state == RUN1) || (state == RUN2);
  assign pass2      = (state == RUN2) || (state == DRAIN2);
  assign run_last   = (cnt == PW'(P - 1));
  assign drain_last = (cnt == PW'(LANES));

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start) state_n = (bus.mode == 2'b01) ? RUN2 : RUN1;
      RUN1:    if (run_last) state_n = DRAIN1;
      DRAIN1:  if (drain_last) state_n = (mode_r == 2'b00) ? DONE : RUN2;
      RUN2:    if (run_last) state_n = DRAIN2;
      DRAIN2:  if (drain_last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // cnt walks {i, g, k} during RUN and counts the LANES+1 cycles of DRAIN
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      state  <= IDLE;
      cnt    <= '0;
      mode_r <= 2'b00;
    end else begin
      state <= state_n;
      if (state_n != state) cnt <= '0;
      else if (state != IDLE && state != DONE) cnt <= cnt + 1'b1;
      if (state == IDLE && bus.start) mode_r <= bus.mode;
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.a_rd_addr = {cnt[PW-1 -: 3], cnt[2:0]};
  assign bus.t_rd_addr = {cnt[PW-1 -: 3], cnt[2:0]};

  generate
    if (GW == 0) begin : g_c_one
      assign bus.c_rd_addr = {pass2, cnt[2:0]};
    end else begin : g_c_multi
      assign bus.c_rd_addr = {pass2, cnt[2:0], cnt[3 +: GW]};
    end
  endgenerate

  logic                    v1;
  logic [PW-1:0]           idx1;
  logic signed [DATA_W-1:0] x;
  logic signed [PRW-1:0]   prod [LANES];
  logic signed [ACC_W-1:0] sum  [LANES];
  logic signed [ACC_W-1:0] acc  [LANES];
  logic signed [ACC_W-1:0] obuf [LANES];
  logic                    dact;
  logic [DLW-1:0]          dl;
  logic [GRW-1:0]          grp_r;

  assign x = pass2 ? $signed(bus.t_rd_data) : $signed(bus.a_rd_data);

  // idx1 is the index whose operands are on the read-data buses this cycle
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      prod[l] = PRW'(x) * PRW'($signed(bus.c_rd_data[l*COEF_W +: COEF_W]));
      sum[l]  = ACC_W'(prod[l]);
      if (idx1[2:0] != 3'd0) sum[l] = sum[l] + acc[l];
    end
  end

  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      v1    <= 1'b0;
      idx1  <= '0;
      dact  <= 1'b0;
      dl    <= '0;
      grp_r <= '0;
      for (int l = 0; l < LANES; l++) begin
        acc[l]  <= '0;
        obuf[l] <= '0;
      end
    end else begin
      v1   <= run;
      idx1 <= cnt;
      if (v1) begin
        for (int l = 0; l < LANES; l++) acc[l] <= sum[l];
      end
      // A completed group reloads the buffer even while the previous drain finishes
      if (v1 && idx1[2:0] == 3'd7) begin
        for (int l = 0; l < LANES; l++) obuf[l] <= sum[l];
        grp_r <= idx1[PW-1:3];
        dact  <= 1'b1;
        dl    <= '0;
      end else if (dact) begin
        if (dl == DLW'(LANES - 1)) dact <= 1'b0;
        else dl <= dl + 1'b1;
      end
    end
  end

  logic signed [ACC_W-1:0] sel, sh_s;
  logic [DATA_W-1:0]       s_val;
  logic [5:0]              wr_addr;

  generate
    if (LANES == 1) begin : g_sel_one
      assign sel = obuf[0];
    end else begin : g_sel_multi
      assign sel = obuf[dl];
    end
  endgenerate

  assign sh_s = sel >>> SHIFT_S;

  always_comb begin
    s_val = DATA_W'(sh_s);
    if (CLIP != 0) begin
      if (sh_s < 0)          s_val = '0;
      else if (sh_s > MAXV)  s_val = DATA_W'(255);
      else                   s_val = DATA_W'(sh_s[7:0]);
    end
  end

  assign wr_addr       = (6'(grp_r) << LW) | 6'(dl);
  assign bus.t_wr_addr = wr_addr;
  assign bus.s_wr_addr = wr_addr;
  assign bus.t_wdata   = DATA_W'(sel >>> SHIFT_T);
  assign bus.s_wdata   = s_val;
  assign bus.t_we      = dact && !pass2;
  assign bus.s_we      = dact && pass2;
endmodule

// File: tb/tb_dct_matmul_engine.sv
// tb/tb_dct_matmul_engine.sv - bench for dct_matmul_engine (LANES=4 clipped, LANES=8 unclipped)
module tb_dct_matmul_engine;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  dct_matmul_engine_if #(.DATA_W(32), .COEF_W(16), .LANES(4)) b4();
  dct_matmul_engine_if #(.DATA_W(32), .COEF_W(16), .LANES(8)) b8();

  dct_matmul_engine #(.DATA_W(32), .COEF_W(16), .LANES(4), .SHIFT_T(8), .SHIFT_S(16), .CLIP(1))
    dut4 (.CLOCK_50_I(clk), .Resetn(resetn), .bus(b4));
  dct_matmul_engine #(.DATA_W(32), .COEF_W(16), .LANES(8), .SHIFT_T(8), .SHIFT_S(16), .CLIP(0))
    dut8 (.CLOCK_50_I(clk), .Resetn(resetn), .bus(b8));

  int a_mem [64];
  int t4 [64], s4 [64], t8 [64], s8 [64];
  int t_pre [64];
  bit pre_req;
  shortint cm [8][8];
  int te [64], se [64];
  int errors = 0;
  int checks = 0;

  function automatic logic [63:0] rom4(input logic [4:0] ad);
    logic [63:0] r;
    int k, j;
    r = '0;
    k = int'(ad[3:1]);
    for (int l = 0; l < 4; l++) begin
      j = int'(ad[0]) * 4 + l;
      r[l*16 +: 16] = ad[4] ? cm[j][k] : cm[k][j];
    end
    return r;
  endfunction

  function automatic logic [127:0] rom8(input logic [3:0] ad);
    logic [127:0] r;
    int k;
    r = '0;
    k = int'(ad[2:0]);
    for (int l = 0; l < 8; l++) r[l*16 +: 16] = ad[3] ? cm[l][k] : cm[k][l];
    return r;
  endfunction

  // Synchronous RAMs and coefficient ROM with one cycle of read latency
  always @(posedge clk) begin
    b4.a_rd_data <= a_mem[b4.a_rd_addr];
    b4.t_rd_data <= t4[b4.t_rd_addr];
    b4.c_rd_data <= rom4(b4.c_rd_addr);
    b8.a_rd_data <= a_mem[b8.a_rd_addr];
    b8.t_rd_data <= t8[b8.t_rd_addr];
    b8.c_rd_data <= rom8(b8.c_rd_addr);
    if (pre_req) begin
      for (int a = 0; a < 64; a++) begin
        t4[a] <= t_pre[a];
        t8[a] <= t_pre[a];
      end
    end
    if (b4.t_we) t4[b4.t_wr_addr] <= b4.t_wdata;
    if (b4.s_we) s4[b4.s_wr_addr] <= b4.s_wdata;
    if (b8.t_we) t8[b8.t_wr_addr] <= b8.t_wdata;
    if (b8.s_we) s8[b8.s_wr_addr] <= b8.s_wdata;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_t();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        longint s = 0;
        for (int k = 0; k < 8; k++) s += longint'(a_mem[i*8+k]) * longint'(cm[k][j]);
        te[i*8+j] = int'(s >>> 8);
      end
  endtask

  task automatic model_s(input bit clip);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        longint s = 0, v;
        for (int k = 0; k < 8; k++) s += longint'(te[i*8+k]) * longint'(cm[j][k]);
        v = s >>> 16;
        if (!clip) se[i*8+j] = int'(v);
        else se[i*8+j] = (v < 0) ? 0 : (v > 255) ? 255 : int'(v);
      end
  endtask

  task automatic preload_t(input int v);
    for (int a = 0; a < 64; a++) begin
      t_pre[a] = v;
      te[a] = v;
    end
    @(negedge clk);
    pre_req = 1'b1;
    @(negedge clk);
    pre_req = 1'b0;
  endtask

  task automatic run(input bit big, input logic [1:0] m, input bit spam,
                     output int lat, output int twe, output int swe, output int swe_early);
    logic tw, sw, dn, pulse;
    lat = -1; twe = 0; swe = 0; swe_early = 0;
    @(negedge clk);
    if (big) begin b8.mode = m; b8.start = 1'b1; end
    else begin b4.mode = m; b4.start = 1'b1; end
    for (int n = 1; n <= 2000; n++) begin
      @(negedge clk);
      pulse = spam && (n == 5 || n == 140);
      if (big) begin b8.start = pulse; b8.mode = pulse ? 2'b00 : m; end
      else begin b4.start = pulse; b4.mode = pulse ? 2'b00 : m; end
      tw = big ? b8.t_we : b4.t_we;
      sw = big ? b8.s_we : b4.s_we;
      dn = big ? b8.done : b4.done;
      if (tw) twe++;
      if (sw) begin
        swe++;
        if (twe < 64) swe_early++;
      end
      if (dn) begin
        lat = n;
        break;
      end
    end
    b4.start = 1'b0;
    b8.start = 1'b0;
  endtask

  task automatic rand_ops(input int amax, input int cmax);
    for (int a = 0; a < 64; a++)
      a_mem[a] = (amax == 0) ? int'($urandom) : int'($urandom_range(2 * amax)) - amax;
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 8; j++)
        cm[k][j] = (cmax == 0) ? shortint'($urandom) : shortint'(int'($urandom_range(2 * cmax)) - cmax);
  endtask

  initial begin
    int lat, twe, swe, early, seen;
    resetn = 1'b0;
    pre_req = 1'b0;
    b4.start = 1'b0; b4.mode = 2'b00;
    b8.start = 1'b0; b8.mode = 2'b00;
    for (int a = 0; a < 64; a++) a_mem[a] = 0;
    for (int k = 0; k < 8; k++) for (int j = 0; j < 8; j++) cm[k][j] = 0;
    repeat (3) @(negedge clk);

    chk("rst_busy", b4.busy, 0);
    chk("rst_done", b4.done, 0);
    chk("rst_t_we", b4.t_we, 0);
    chk("rst_s_we", b4.s_we, 0);
    chk("rst_t_wr_addr", b4.t_wr_addr, 0);
    chk("rst_s_wr_addr", b4.s_wr_addr, 0);
    chk("rst_t_wdata", b4.t_wdata, 0);
    chk("rst_s_wdata", b4.s_wdata, 0);
    chk("rst_a_rd_addr", b4.a_rd_addr, 0);
    chk("rst_c_rd_addr", b4.c_rd_addr, 0);
    chk("rst8_busy", b8.busy, 0);
    chk("rst8_t_we", b8.t_we, 0);
    @(negedge clk);
    resetn = 1'b1;

    // Identity: C = 256*I reproduces A in T
    for (int a = 0; a < 64; a++) a_mem[a] = 10 * (a / 8) + (a % 8);
    for (int k = 0; k < 8; k++) for (int j = 0; j < 8; j++) cm[k][j] = (k == j) ? 256 : 0;
    run(0, 2'b00, 0, lat, twe, swe, early);
    chk("id_latency", lat, 134);
    chk("id_t_we_count", twe, 64);
    chk("id_s_we_count", swe, 0);
    for (int a = 0; a < 64; a++) chk($sformatf("id_T[%0d]", a), t4[a], a_mem[a]);
    @(negedge clk);
    chk("id_busy_after_done", b4.busy, 0);

    // Row sum: every T word = (1+..+8)*256 >>> 8 = 36
    for (int a = 0; a < 64; a++) a_mem[a] = (a % 8) + 1;
    for (int k = 0; k < 8; k++) for (int j = 0; j < 8; j++) cm[k][j] = 256;
    run(0, 2'b00, 0, lat, twe, swe, early);
    for (int a = 0; a < 64; a++) chk($sformatf("rowsum_T[%0d]", a), t4[a], 36);

    // Random full-range T-only pass
    rand_ops(0, 0);
    model_t();
    run(0, 2'b00, 0, lat, twe, swe, early);
    chk("rnd_t_latency", lat, 134);
    for (int a = 0; a < 64; a++) chk($sformatf("rnd_T[%0d]", a), t4[a], te[a]);

    // Clip high: 8*8192*32767 >>> 16 = 32767
    for (int k = 0; k < 8; k++) for (int j = 0; j < 8; j++) cm[k][j] = 32767;
    preload_t(8192);
    run(0, 2'b01, 0, lat, twe, swe, early);
    chk("cliphi_latency", lat, 134);
    chk("cliphi_t_we_count", twe, 0);
    chk("cliphi_s_we_count", swe, 64);
    for (int a = 0; a < 64; a++) chk($sformatf("cliphi_S[%0d]", a), s4[a], 255);
    run(1, 2'b01, 0, lat, twe, swe, early);
    chk("noclip8_latency", lat, 74);
    for (int a = 0; a < 64; a++) chk($sformatf("noclip8_S[%0d]", a), s8[a], 32767);

    // Clip low: 8*(-100)*1000 >>> 16 = -13
    for (int k = 0; k < 8; k++) for (int j = 0; j < 8; j++) cm[k][j] = 1000;
    preload_t(-100);
    run(0, 2'b01, 0, lat, twe, swe, early);
    for (int a = 0; a < 64; a++) chk($sformatf("cliplo_S[%0d]", a), s4[a], 0);

    // Chained random, with start pulses while busy
    rand_ops(2000, 300);
    model_t();
    model_s(1);
    run(0, 2'b10, 1, lat, twe, swe, early);
    chk("chain_latency", lat, 267);
    chk("chain_t_we_count", twe, 64);
    chk("chain_s_we_count", swe, 64);
    chk("chain_s_we_in_pass1", early, 0);
    for (int a = 0; a < 64; a++) chk($sformatf("chain_T[%0d]", a), t4[a], te[a]);
    for (int a = 0; a < 64; a++) chk($sformatf("chain_S[%0d]", a), s4[a], se[a]);
    @(negedge clk);
    chk("chain_busy_after", b4.busy, 0);
    repeat (3) @(negedge clk);
    chk("chain_stays_idle", b4.busy, 0);

    // Mode 11 behaves as 10
    rand_ops(2000, 300);
    model_t();
    model_s(1);
    run(0, 2'b11, 0, lat, twe, swe, early);
    chk("mode11_latency", lat, 267);
    for (int a = 0; a < 64; a++) chk($sformatf("mode11_S[%0d]", a), s4[a], se[a]);

    // LANES=8, CLIP=0 chained random
    rand_ops(2000, 300);
    model_t();
    model_s(0);
    run(1, 2'b10, 0, lat, twe, swe, early);
    chk("l8_chain_latency", lat, 147);
    for (int a = 0; a < 64; a++) chk($sformatf("l8_T[%0d]", a), t8[a], te[a]);
    for (int a = 0; a < 64; a++) chk($sformatf("l8_S[%0d]", a), s8[a], se[a]);

    // Asynchronous reset in the middle of a write burst, then a clean rerun
    rand_ops(0, 0);
    model_t();
    @(negedge clk);
    b4.mode = 2'b00;
    b4.start = 1'b1;
    @(negedge clk);
    b4.start = 1'b0;
    seen = 0;
    for (int n = 0; n < 300 && seen == 0; n++) begin
      @(negedge clk);
      if (b4.t_we) seen = 1;
    end
    chk("midrst_we_seen", seen, 1);
    resetn = 1'b0;
    #1;
    chk("midrst_t_we", b4.t_we, 0);
    chk("midrst_busy", b4.busy, 0);
    chk("midrst_done", b4.done, 0);
    @(negedge clk);
    resetn = 1'b1;
    run(0, 2'b00, 0, lat, twe, swe, early);
    chk("postrst_latency", lat, 134);
    chk("postrst_t_we_count", twe, 64);
    for (int a = 0; a < 64; a++) chk($sformatf("postrst_T[%0d]", a), t4[a], te[a]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
